ahb_dmem_slave: RTL and testbench
=================================

// Module: ahb_dmem_slave
// PURPOSE
//  AHB-Lite slave that serves the core's data-side master (HADDR_D/HTRANS_D/...) from an on-chip data SRAM.
//  Tracks address/data phases, generates byte enables from HSIZE/HADDR, inserts optional wait states and
//  returns two-cycle ERROR for illegal transfers. A 1-entry write buffer resolves the SRAM port conflict.
// PARAMETERS
//  BASE_ADDR    32'h0000_0000  byte base of the SRAM window; must be aligned to DEPTH_WORDS*4
//  DEPTH_WORDS  4096           SRAM depth in 32-bit words, power of 2; AW = $clog2(DEPTH_WORDS)
//  WAIT_STATES  0              HREADYOUT-low cycles inserted in every OKAY data phase (0..7)
//  JUSTIFY      1              1: read data right-justified by byte offset, write data taken from low lanes
//                              (our core's convention); 0: standard AHB lane placement
// PORTS
//  CLK        in   1   clock
//  RST        in   1   synchronous, active-high reset
//  HSEL       in   1   slave select (address phase)
//  HADDR      in   32  byte address
//  HTRANS     in   2   IDLE/BUSY/NONSEQ/SEQ; NONSEQ and SEQ treated identically
//  HWRITE     in   1   1 = write
//  HSIZE      in   3   0 byte, 1 half, 2 word; >2 illegal
//  HBURST     in   3   ignored
//  HPROT      in   4   ignored
//  HMASTLOCK  in   1   ignored
//  HWDATA     in   32  write data, valid in data phase
//  HREADY     in   1   bus-level ready; address phase accepted only when high
//  HREADYOUT  out  1   this slave's ready
//  HRESP      out  1   0 OKAY, 1 ERROR
//  HRDATA     out  32  read data, valid when HREADYOUT=1 in a read data phase
// BEHAVIOUR
//  Reset: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, data phase and write buffer invalid.
//  Clock and reset are fixed: one clock CLK, synchronous active-high RST.
//  RST mid-transfer aborts the data phase and drops any buffered write; no SRAM write occurs in the RST cycle.
//  Accept: HSEL & HTRANS[1] & HREADY -> latch addr, write, size into the data-phase register.
//  IDLE/BUSY, or HSEL=0: no access; the next data phase is zero-wait OKAY.
//  Illegal: HSIZE>2; half with HADDR[0]=1; word with HADDR[1:0]!=0; HADDR[31:AW+2] != BASE_ADDR[31:AW+2].
//  Illegal transfers never touch the SRAM and get ERROR: ERR1 (HREADYOUT=0, HRESP=1),
//  then ERR2 (HREADYOUT=1, HRESP=1). Wait states are not applied to ERROR.
//  FSM IDLE->WAIT when a legal transfer is accepted and WAIT_STATES>0; counter loads WAIT_STATES.
//  WAIT: HREADYOUT=0, counter decrements; the final data cycle drives HREADYOUT=1 -> IDLE.
//  IDLE->ERR1 on an illegal accept. ERR1->ERR2->IDLE unconditionally.
//  A new accept in ERR2 or at the last WAIT cycle is honoured back-to-back.
//  Byte enables (word index HADDR[AW+1:2]): byte 4'b0001<<HADDR[1:0]; half 4'b0011<<HADDR[1:0]; word 4'b1111.
//  JUSTIFY=1 write: HWDATA[7:0]/[15:0] is replicated to the addressed lanes.
//  JUSTIFY=1 read: HRDATA = word >> (8*HADDR[1:0]), upper bits zero. The master sign-extends.
//  Read latency: the SRAM read is issued in the address-phase cycle, so data is ready in the first data cycle.
//  HRDATA is held from a data register through wait states.
//  SRAM port priority per cycle: (1) read accepted in the address phase; (2) write data phase with
//  HREADYOUT=1, written directly from HWDATA; (3) drain of the write buffer.
//  A write data phase that collides with (1) loads the buffer (addr, be, data), valid=1.
//  The buffer drains on the next cycle without (1).
//  Invariant: a buffer fill always coincides with a read address phase, so the next cycle is that read's
//  data phase, not a write data phase. (2) and (3) never coincide and depth 1 suffices.
//  The bench asserts that a fill while valid=1 never occurs.
//  Forwarding: a read whose word index matches a valid buffer entry merges the buffered bytes
//  (per be) over the SRAM data before justification.
// STRUCTURE
//  Shared package ahb_pkg: HTRANS_*, HSIZE_*, HBURST_*, HPROT_DATA constants, and the state enum
//  {IDLE, WAIT, ERR1, ERR2}. These are shared with the data master.
//  Sub-module sram_sp_be: DEPTH_WORDS x 32, single port, byte-write enables, 1-cycle sync read.
//  Its output holds until the next read.
//  Top: phase register, FSM, lane logic, write buffer, forwarding mux.
// TESTING
//  1 SW 0x11223344 @0x100, then LW @0x100 -> HRDATA=0x11223344, HREADYOUT never low (WAIT_STATES=0).
//  2 SB 0xAB @0x101, then LBU @0x101 -> HRDATA=0x000000AB; LW @0x100 -> 0x1122AB44.
//  3 SW 0xDEADBEEF @0x200, with LW @0x200 in the cycle after its address phase -> buffer fills,
//    forwarded HRDATA=0xDEADBEEF; the buffer drains on the next idle cycle.
//  4 LW @0x102 (misaligned) -> HREADYOUT 0 then 1 with HRESP=1 on both cycles; SRAM unchanged.
//  5 HADDR=BASE_ADDR+DEPTH_WORDS*4 -> same two-cycle ERROR. A NONSEQ accepted in ERR2 completes OKAY.
//  6 WAIT_STATES=2: LW -> exactly 2 cycles with HREADYOUT=0, HRDATA stable.
//    RST asserted mid-WAIT -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0, no write performed.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the data-slave state type, also used by the core's data master.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  localparam logic [3:0] HPROT_DATA = 4'b0001;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_e;

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
    case (size)
      HSIZE_BYTE: return 4'b0001 << off;
      HSIZE_HALF: return 4'b0011 << off;
      default:    return 4'b1111;
    endcase
  endfunction

  // Core convention: narrow write data arrives in the low lanes and is copied to every lane.
  function automatic logic [31:0] wr_replicate(input logic [2:0] size, input logic [31:0] data);
    case (size)
      HSIZE_BYTE: return {4{data[7:0]}};
      HSIZE_HALF: return {2{data[15:0]}};
      default:    return data;
    endcase
  endfunction

  function automatic logic [31:0] rd_justify(input logic [2:0] size, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    case (size)
      HSIZE_BYTE: return {24'h0, s[7:0]};
      HSIZE_HALF: return {16'h0, s[15:0]};
      default:    return s;
    endcase
  endfunction

endpackage

// File: rtl/ahb_dmem_slave_if.sv
// AHB-Lite data-side bus bundle between the core's data master and the data SRAM slave.
interface ahb_dmem_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/sram_sp_be.sv
// Single-port data SRAM, 32-bit words with byte write enables and a registered read that holds
// its value until the next read. One byte-lane array per lane.
module sram_sp_be #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_lane_q;

      // An enabled access with no byte enables is a read.
      always_ff @(posedge clk) begin
        if (en && be[gi]) mem[addr] <= wdata[8*gi +: 8];
        if (en && be == 4'b0000) rd_lane_q <= mem[addr];
      end

      assign rdata[8*gi +: 8] = rd_lane_q;
    end
  endgenerate

endmodule

// File: rtl/ahb_dmem_slave.sv
// AHB-Lite data-side slave in front of the on-chip data SRAM: phase tracking, optional wait states,
// two-cycle ERROR, byte lanes, and a one-entry write buffer with read forwarding.
module ahb_dmem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          WAIT_STATES = 0,
  parameter bit          JUSTIFY     = 1'b1
) (
  input logic              CLK,
  input logic              RST,
  ahb_dmem_slave_if.slave  bus
);
  import ahb_pkg::*;

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          dp_valid_q, dp_valid_d;
  logic          dp_write_q, dp_write_d;
  logic          dp_first_q, dp_first_d;
  logic [AW-1:0] dp_idx_q, dp_idx_d;
  logic [1:0]    dp_off_q, dp_off_d;
  logic [2:0]    dp_size_q, dp_size_d;
  logic [3:0]    dp_be_q, dp_be_d;
  logic          buf_valid_q, buf_valid_d;
  logic [AW-1:0] buf_idx_q, buf_idx_d;
  logic [3:0]    buf_be_q, buf_be_d;
  logic [31:0]   buf_data_q, buf_data_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          hready_out, hresp_out;
  logic          accept, legal, rd_acc, wr_now, buf_fill, buf_hit, rd_live;
  logic          sram_en;
  logic [3:0]    sram_be;
  logic [AW-1:0] sram_idx;
  logic [31:0]   sram_wdata, sram_rdata, wr_lanes, merged, rd_word;
  logic          unused_ok;

  assign unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0]};

  assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign legal  = (bus.HSIZE <= 3'd2)
               && !(bus.HSIZE == HSIZE_HALF && bus.HADDR[0])
               && !(bus.HSIZE == HSIZE_WORD && bus.HADDR[1:0] != 2'b00)
               && (bus.HADDR[31:AW+2] == BASE_ADDR[31:AW+2]);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hready_out = 1'b1;
    hresp_out  = 1'b0;
    case (state_q)
      IDLE: ;
      WAIT: begin
        hready_out = (cnt_q == 3'd0);
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
      end
      ERR1: begin
        hready_out = 1'b0;
        hresp_out  = 1'b1;
        state_d    = ERR2;
      end
      ERR2: hresp_out = 1'b1;
      default: state_d = IDLE;
    endcase
    // Any cycle that completes a data phase may also open the next one.
    if (hready_out) begin
      state_d = IDLE;
      if (accept) begin
        if (!legal) begin
          state_d = ERR1;
        end else if (WAIT_STATES > 0) begin
          state_d = WAIT;
          cnt_d   = 3'(WAIT_STATES);
        end
      end
    end
  end

  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_idx_d   = dp_idx_q;
    dp_off_d   = dp_off_q;
    dp_size_d  = dp_size_q;
    dp_be_d    = dp_be_q;
    dp_first_d = 1'b0;
    if (hready_out) begin
      dp_valid_d = accept & legal;
      dp_first_d = accept & legal;
      dp_write_d = bus.HWRITE;
      dp_idx_d   = bus.HADDR[AW+1:2];
      dp_off_d   = bus.HADDR[1:0];
      dp_size_d  = bus.HSIZE;
      dp_be_d    = byte_en(bus.HSIZE, bus.HADDR[1:0]);
    end
  end

  assign rd_acc   = hready_out & accept & legal & ~bus.HWRITE;
  assign wr_now   = dp_valid_q & dp_write_q & hready_out;
  assign wr_lanes = JUSTIFY ? wr_replicate(dp_size_q, bus.HWDATA) : bus.HWDATA;

  // Port arbitration: new read > completing write > buffer drain.
  always_comb begin
    sram_en     = 1'b0;
    sram_be     = 4'b0000;
    sram_idx    = bus.HADDR[AW+1:2];
    sram_wdata  = wr_lanes;
    buf_fill    = 1'b0;
    buf_valid_d = buf_valid_q;
    buf_idx_d   = buf_idx_q;
    buf_be_d    = buf_be_q;
    buf_data_d  = buf_data_q;
    if (rd_acc) begin
      sram_en = 1'b1;
      if (wr_now) begin
        buf_fill    = 1'b1;
        buf_valid_d = 1'b1;
        buf_idx_d   = dp_idx_q;
        buf_be_d    = dp_be_q;
        buf_data_d  = wr_lanes;
      end
    end else if (wr_now) begin
      sram_en  = 1'b1;
      sram_be  = dp_be_q;
      sram_idx = dp_idx_q;
    end else if (buf_valid_q) begin
      sram_en     = 1'b1;
      sram_be     = buf_be_q;
      sram_idx    = buf_idx_q;
      sram_wdata  = buf_data_q;
      buf_valid_d = 1'b0;
    end
  end

  sram_sp_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk   (CLK),
    .en    (sram_en & ~RST),
    .be    (sram_be),
    .addr  (sram_idx),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );

  assign buf_hit = buf_valid_q & (buf_idx_q == dp_idx_q);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fwd
      assign merged[8*gi +: 8] = (buf_hit & buf_be_q[gi]) ? buf_data_q[8*gi +: 8]
                                                           : sram_rdata[8*gi +: 8];
    end
  endgenerate

  // SRAM data is only fresh in the first data cycle; the hold register covers wait states.
  assign rd_word    = JUSTIFY ? rd_justify(dp_size_q, dp_off_q, merged) : merged;
  assign rd_live    = dp_first_q & ~dp_write_q;
  assign rdata_d    = rd_live ? rd_word : rdata_q;

  assign bus.HREADYOUT = hready_out;
  assign bus.HRESP     = hresp_out;
  assign bus.HRDATA    = rdata_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_first_q  <= 1'b0;
      dp_idx_q    <= '0;
      dp_off_q    <= 2'b00;
      dp_size_q   <= 3'd0;
      dp_be_q     <= 4'b0000;
      buf_valid_q <= 1'b0;
      buf_idx_q   <= '0;
      buf_be_q    <= 4'b0000;
      buf_data_q  <= 32'h0;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_first_q  <= dp_first_d;
      dp_idx_q    <= dp_idx_d;
      dp_off_q    <= dp_off_d;
      dp_size_q   <= dp_size_d;
      dp_be_q     <= dp_be_d;
      buf_valid_q <= buf_valid_d;
      buf_idx_q   <= buf_idx_d;
      buf_be_q    <= buf_be_d;
      buf_data_q  <= buf_data_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ahb_dmem_slave.sv
// Directed bench for ahb_dmem_slave: a zero-wait instance for lanes, forwarding and errors,
// and a two-wait-state instance for wait timing and mid-transfer reset.
module tb_ahb_dmem_slave;
  import ahb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        tgt;
  logic        m_sel, m_write;
  logic [1:0]  m_trans;
  logic [2:0]  m_size;
  logic [31:0] m_addr, m_wdata;

  ahb_dmem_slave_if bus0();
  ahb_dmem_slave_if bus2();

  assign bus0.HSEL      = m_sel & ~tgt;
  assign bus0.HADDR     = m_addr;
  assign bus0.HTRANS    = m_trans;
  assign bus0.HWRITE    = m_write;
  assign bus0.HSIZE     = m_size;
  assign bus0.HBURST    = HBURST_SINGLE;
  assign bus0.HPROT     = HPROT_DATA;
  assign bus0.HMASTLOCK = 1'b0;
  assign bus0.HWDATA    = m_wdata;
  assign bus0.HREADY    = bus0.HREADYOUT;

  assign bus2.HSEL      = m_sel & tgt;
  assign bus2.HADDR     = m_addr;
  assign bus2.HTRANS    = m_trans;
  assign bus2.HWRITE    = m_write;
  assign bus2.HSIZE     = m_size;
  assign bus2.HBURST    = HBURST_SINGLE;
  assign bus2.HPROT     = HPROT_DATA;
  assign bus2.HMASTLOCK = 1'b0;
  assign bus2.HWDATA    = m_wdata;
  assign bus2.HREADY    = bus2.HREADYOUT;

  ahb_dmem_slave #(.WAIT_STATES(0)) dut0 (.CLK(clk), .RST(rst), .bus(bus0));
  ahb_dmem_slave #(.WAIT_STATES(2)) dut2 (.CLK(clk), .RST(rst), .bus(bus2));

  logic        obs_rdy, obs_rsp;
  logic [31:0] obs_rdata;
  assign obs_rdy   = tgt ? bus2.HREADYOUT : bus0.HREADYOUT;
  assign obs_rsp   = tgt ? bus2.HRESP     : bus0.HRESP;
  assign obs_rdata = tgt ? bus2.HRDATA    : bus0.HRDATA;

  int n_checks = 0;
  int n_errors = 0;
  int low_cnt  = 0;
  int overfill = 0;
  logic mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && !bus0.HREADYOUT) low_cnt <= low_cnt + 1;
    if (dut0.buf_fill && dut0.buf_valid_q) overfill <= overfill + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic ap(input logic wr, input logic [2:0] sz, input logic [31:0] a);
    m_sel = 1'b1; m_trans = HTRANS_NONSEQ; m_write = wr; m_size = sz; m_addr = a;
  endtask

  task automatic idle();
    m_sel = 1'b0; m_trans = HTRANS_IDLE; m_write = 1'b0;
  endtask

  // Zero-wait single transfers on dut0.
  task automatic wr(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    ap(1'b1, sz, a); cyc();
    idle(); m_wdata = d; cyc();
  endtask

  task automatic rd(input string tag, input logic [2:0] sz, input logic [31:0] a,
                    input logic [31:0] exp);
    ap(1'b0, sz, a); cyc();
    idle(); smp(); check_eq(tag, obs_rdata, exp); cyc();
  endtask

  task automatic chk_rr(input string tag, input logic rdy, input logic rsp);
    check_eq({tag, "_rdy"}, {31'h0, obs_rdy}, {31'h0, rdy});
    check_eq({tag, "_rsp"}, {31'h0, obs_rsp}, {31'h0, rsp});
  endtask

  initial begin
    tgt = 1'b0; m_addr = 32'h0; m_size = 3'd0; m_wdata = 32'h0; rst = 1'b1;
    idle();
    cyc();
    smp();
    chk_rr("reset", 1'b1, 1'b0);
    check_eq("reset_rdata", obs_rdata, 32'h0);
    cyc();
    rst = 1'b0;
    mon_en = 1'b1;

    // Word store/load
    wr(HSIZE_WORD, 32'h100, 32'h1122_3344);
    rd("t1_lw", HSIZE_WORD, 32'h100, 32'h1122_3344);

    // Byte and halfword lanes, right-justified reads
    wr(HSIZE_BYTE, 32'h101, 32'h0000_00AB);
    rd("t2_lbu", HSIZE_BYTE, 32'h101, 32'h0000_00AB);
    rd("t2_lw", HSIZE_WORD, 32'h100, 32'h1122_AB44);
    rd("t2_lhu_hi", HSIZE_HALF, 32'h102, 32'h0000_1122);
    rd("t2_lhu_lo", HSIZE_HALF, 32'h100, 32'h0000_AB44);
    wr(HSIZE_HALF, 32'h102, 32'h0000_7788);
    rd("t2_lw_sh", HSIZE_WORD, 32'h100, 32'h7788_AB44);

    // Write data phase colliding with a read address phase: buffer + forwarding
    ap(1'b1, HSIZE_WORD, 32'h200); cyc();
    m_wdata = 32'hDEAD_BEEF; ap(1'b0, HSIZE_WORD, 32'h200); cyc();
    idle(); smp(); check_eq("t3_fwd", obs_rdata, 32'hDEAD_BEEF); cyc();
    ap(1'b1, HSIZE_BYTE, 32'h201); cyc();
    m_wdata = 32'h0000_0055; ap(1'b0, HSIZE_WORD, 32'h200); cyc();
    idle(); smp(); check_eq("t3_fwd_be", obs_rdata, 32'hDEAD_55EF); cyc();
    rd("t3_drained", HSIZE_WORD, 32'h200, 32'hDEAD_55EF);
    ap(1'b1, HSIZE_WORD, 32'h204); cyc();
    m_wdata = 32'h0102_0304; ap(1'b0, HSIZE_WORD, 32'h200); cyc();
    idle(); smp(); check_eq("t3_nohit", obs_rdata, 32'hDEAD_55EF); cyc();
    rd("t3_other", HSIZE_WORD, 32'h204, 32'h0102_0304);
    ap(1'b0, HSIZE_BYTE, 32'h203); cyc();
    ap(1'b0, HSIZE_WORD, 32'h100); smp(); check_eq("t3_b2b_lbu", obs_rdata, 32'h0000_00DE); cyc();
    idle(); smp(); check_eq("t3_b2b_lw", obs_rdata, 32'h7788_AB44); cyc();
    mon_en = 1'b0;
    check_eq("zero_wait_low_cycles", low_cnt, 0);

    // Misaligned and illegal-size transfers
    ap(1'b0, HSIZE_WORD, 32'h102); cyc();
    idle(); smp(); chk_rr("t4_err1", 1'b0, 1'b1); cyc();
    smp(); chk_rr("t4_err2", 1'b1, 1'b1); cyc();
    smp(); chk_rr("t4_after", 1'b1, 1'b0); cyc();
    ap(1'b1, HSIZE_WORD, 32'h102); cyc();
    idle(); m_wdata = 32'hFFFF_FFFF; smp(); chk_rr("t4_wr_err1", 1'b0, 1'b1); cyc();
    cyc();
    rd("t4_unchanged", HSIZE_WORD, 32'h100, 32'h7788_AB44);
    ap(1'b0, 3'd3, 32'h100); cyc();
    idle(); smp(); chk_rr("t4_size3", 1'b0, 1'b1); cyc(); cyc();
    ap(1'b0, HSIZE_HALF, 32'h101); cyc();
    idle(); smp(); chk_rr("t4_half_odd", 1'b0, 1'b1); cyc(); cyc();

    // Out-of-window address, NONSEQ accepted in ERR2, last legal word
    ap(1'b0, HSIZE_WORD, 32'h4000); cyc();
    idle(); smp(); chk_rr("t5_err1", 1'b0, 1'b1); cyc();
    ap(1'b0, HSIZE_WORD, 32'h200); smp(); chk_rr("t5_err2", 1'b1, 1'b1); cyc();
    idle(); smp(); chk_rr("t5_okay", 1'b1, 1'b0);
    check_eq("t5_rdata", obs_rdata, 32'hDEAD_55EF); cyc();
    wr(HSIZE_WORD, 32'h3FFC, 32'hA5A5_5A5A);
    rd("t5_top_word", HSIZE_WORD, 32'h3FFC, 32'hA5A5_5A5A);

    // Two wait states on dut2
    tgt = 1'b1;
    ap(1'b1, HSIZE_WORD, 32'h300); cyc();
    idle(); m_wdata = 32'hCAFE_F00D; smp(); chk_rr("t6_w1", 1'b0, 1'b0); cyc();
    smp(); chk_rr("t6_w2", 1'b0, 1'b0); cyc();
    smp(); chk_rr("t6_w3", 1'b1, 1'b0); cyc();
    ap(1'b0, HSIZE_WORD, 32'h300); cyc();
    idle(); smp(); chk_rr("t6_r1", 1'b0, 1'b0); check_eq("t6_r1_data", obs_rdata, 32'hCAFE_F00D); cyc();
    smp(); chk_rr("t6_r2", 1'b0, 1'b0); check_eq("t6_r2_data", obs_rdata, 32'hCAFE_F00D); cyc();
    smp(); chk_rr("t6_r3", 1'b1, 1'b0); check_eq("t6_r3_data", obs_rdata, 32'hCAFE_F00D); cyc();
    smp(); chk_rr("t6_r_done", 1'b1, 1'b0); cyc();

    // Reset in the final wait cycle of a write: no write, clean outputs
    ap(1'b1, HSIZE_WORD, 32'h300); cyc();
    idle(); m_wdata = 32'h1234_5678; cyc();
    cyc();
    rst = 1'b1; cyc();
    rst = 1'b0; smp(); chk_rr("t6_rst", 1'b1, 1'b0); check_eq("t6_rst_rdata", obs_rdata, 32'h0); cyc();
    ap(1'b0, HSIZE_WORD, 32'h300); cyc();
    idle(); cyc(); cyc();
    smp(); chk_rr("t6_rb", 1'b1, 1'b0); check_eq("t6_rb_data", obs_rdata, 32'hCAFE_F00D); cyc();

    check_eq("buf_overfill", overfill, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
